stk_ctr: RTL and testbench
==========================

Name: stk_ctr

Overview:
- Parametrised up/down counter for the memory stage; the next generation of the stack-pointer and PC counter.
- Adds a programmable step and configurable bounds [LO_LIM, HI_LIM].
- Adds wrap or saturate mode, sticky overflow/underflow flags and a self-timed burst mode that performs N steps without per-cycle control.
- Drives the stack pointer for multi-word push/pop and block-transfer addressing.

Parameters:
WIDTH, 10, counter width in bits
STEP_W, 3, width of step input
LEN_W, 4, width of burst length input
RESET_VAL, all ones, value loaded on reset
LO_LIM, 0, lowest legal counter value
HI_LIM, all ones, highest legal counter value
SAT, 0, 0 = wrap within [LO_LIM, HI_LIM], 1 = saturate at bound

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-low reset
en  input  1  step/load enable; in burst, 0 pauses
dir  input  1  1 = increment, 0 = decrement
step  input  STEP_W  magnitude per step; 0 = hold
jmp  input  1  load jmpLoc when en=1
jmpLoc  input  WIDTH  load value
burstStart  input  1  start burst (IDLE only)
burstLen  input  LEN_W  number of steps in burst; 0 = no-op
clrFlags  input  1  clear sticky flags
ctrOut  output  WIDTH  current count (registered)
ovf  output  1  sticky: an increment crossed HI_LIM
unf  output  1  sticky: a decrement crossed LO_LIM
busy  output  1  burst in progress
atHi  output  1  ctrOut == HI_LIM (combinational from register)
atLo  output  1  ctrOut == LO_LIM

Behaviour:
- Reset (rst=0, async): ctrOut=RESET_VAL, ovf=0, unf=0, busy=0, state=IDLE, burst counter=0. Deassertion is synchronised externally.
- Legal configuration: LO_LIM <= RESET_VAL <= HI_LIM; 2^STEP_W-1 <= HI_LIM-LO_LIM+1. Configurations outside this are undefined.
- Arithmetic: nxt = ctrOut ± step, computed in WIDTH+1 bits.
  - Overflow: inc and nxt > HI_LIM.
  - Underflow: dec and nxt < LO_LIM (borrow included).
  - SAT=0: overflow wraps to LO_LIM + (nxt - HI_LIM - 1); underflow wraps to HI_LIM - (LO_LIM - nxt - 1).
  - SAT=1: clamp to HI_LIM or LO_LIM.
  - Either mode sets ovf/unf on the same edge the count updates, visible next cycle.
- IDLE, single-cycle operation when en=1:
  - jmp=1: ctrOut <= jmpLoc. jmp has priority over step. No flag change. jmpLoc outside the bounds is loaded unchanged.
  - Otherwise: apply step in dir.
  - step=0: hold.
  - en=0: hold.
- Burst:
  - In IDLE, burstStart=1 with burstLen!=0 latches dir, step and burstLen into internal registers, then moves to RUN. busy=1 from the next cycle.
  - On the start cycle the normal IDLE operation (en/jmp) also executes.
  - burstStart with burstLen=0: no state change.
- RUN:
  - Each cycle with en=1 applies one latched step and decrements the remaining count. en=0 pauses with no change.
  - The step that takes remaining to 0 returns to IDLE; busy=0 the cycle after the last step. Latency: N steps take N enabled cycles.
  - en=1 and jmp=1: loads jmpLoc and aborts to IDLE (busy=0 next cycle). Flags are unaffected.
  - burstStart, dir and step are ignored in RUN.
- Flags:
  - ovf/unf are sticky until clrFlags=1.
  - clrFlags has priority over a same-cycle set. Flags are cleared and the count still updates.
- Reset asserted mid-burst: immediate return to reset values.

Decomposition:
- Shared package stk_pkg:
  - state enum (IDLE, RUN)
  - a default-width constant
  - a function computing the bounded next value and ovf/unf for given (cur, step, dir, SAT, limits)
- One sub-module, stk_ctr_arith: combinational bounded add/subtract returning {nxt, ovf, unf}. Used for both single and burst steps.
- FSM, burst counter and flag registers live in stk_ctr.

Test Plan:
Use WIDTH=4, STEP_W=3, LO_LIM=2, HI_LIM=13, RESET_VAL=13.
1. Reset and jump: rst low mid-operation -> ctrOut=13, flags 0, busy 0, atHi=1 immediately. en=1, jmp=1, jmpLoc=5, dir=1, step=3 -> ctrOut=5 (jmp wins).
2. Wrap and flags (SAT=0): ctrOut=12, inc step 3 -> ctrOut=3, ovf=1. Then dec step 4 from 3 -> ctrOut=11, unf=1. Same-cycle clrFlags plus overflowing step -> flags 0, count updated.
3. Saturate (SAT=1): ctrOut=12, inc step 3 -> ctrOut=13, ovf=1. Then dec step 7 from 4 -> ctrOut=2, unf=1, atLo=1.
4. Burst: ctrOut=4, burstStart, burstLen=3, dir=1, step=2 -> ctrOut 6, 8, 10 on three enabled cycles, busy high throughout, low one cycle after 10. en dropped for 2 cycles mid-burst -> count holds, burst length extends by 2.
5. Burst abort and no-ops: in RUN, en=1, jmp=1, jmpLoc=7 -> ctrOut=7, busy=0 next cycle. burstStart with burstLen=0 -> stays IDLE. step=0 with en=1 -> ctrOut unchanged.

Source files
------------

// File: rtl/stk_pkg.sv
// Shared types and bounded-step arithmetic for the stack/PC counter.
package stk_pkg;

    localparam int DEF_WIDTH = 10;
    localparam int CALC_W    = 33;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    typedef struct packed {
        logic [CALC_W-1:0] nxt;
        logic              ovf;
        logic              unf;
    } step_res_t;

    // Arithmetic runs one bit wider than any legal count, so an increment
    // cannot lose its carry and a decrement below zero shows as stp > cur.
    function automatic step_res_t bounded_step(
        input logic [CALC_W-1:0] cur,
        input logic [CALC_W-1:0] stp,
        input logic              dir,
        input logic              sat,
        input logic [CALC_W-1:0] lo,
        input logic [CALC_W-1:0] hi
    );
        localparam logic [CALC_W-1:0] ONE = CALC_W'(1);
        step_res_t         res;
        logic [CALC_W-1:0] sum;
        res = '0;
        sum = '0;
        if (dir) begin
            sum = cur + stp;
            if (sum > hi) begin
                res.ovf = 1'b1;
                res.nxt = sat ? hi : (lo + (sum - hi - ONE));
            end else begin
                res.nxt = sum;
            end
        end else begin
            sum = cur - stp;
            if ((stp > cur) || (sum < lo)) begin
                res.unf = 1'b1;
                res.nxt = sat ? lo : (hi - (lo - sum - ONE));
            end else begin
                res.nxt = sum;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/stk_ctr_arith.sv
// Combinational bounded add/subtract with wrap or saturate at the limits.
module stk_ctr_arith
    import stk_pkg::*;
#(
    parameter int               WIDTH  = DEF_WIDTH,
    parameter int               STEP_W = 3,
    parameter logic [WIDTH-1:0] LO_LIM = '0,
    parameter logic [WIDTH-1:0] HI_LIM = '1,
    parameter bit               SAT    = 1'b0
)(
    input  logic [WIDTH-1:0]  cur,
    input  logic [STEP_W-1:0] step,
    input  logic              dir,
    output logic [WIDTH-1:0]  nxt,
    output logic              ovf,
    output logic              unf
);

    step_res_t res;
    logic      unused_hi;

    always_comb begin
        res = bounded_step(CALC_W'(cur), CALC_W'(step), dir, SAT,
                           CALC_W'(LO_LIM), CALC_W'(HI_LIM));
        // A zero step is a hold even when the count sits outside the bounds.
        if (step == '0) begin
            res.nxt = CALC_W'(cur);
            res.ovf = 1'b0;
            res.unf = 1'b0;
        end
    end

    assign nxt       = res.nxt[WIDTH-1:0];
    assign ovf       = res.ovf;
    assign unf       = res.unf;
    assign unused_hi = ^res.nxt[CALC_W-1:WIDTH];

endmodule

// File: rtl/stk_ctr.sv
// Bounded up/down stack-pointer counter with jump load, sticky flags and burst stepping.
module stk_ctr
    import stk_pkg::*;
#(
    parameter int               WIDTH     = DEF_WIDTH,
    parameter int               STEP_W    = 3,
    parameter int               LEN_W     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '1,
    parameter logic [WIDTH-1:0] LO_LIM    = '0,
    parameter logic [WIDTH-1:0] HI_LIM    = '1,
    parameter bit               SAT       = 1'b0
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              dir,
    input  logic [STEP_W-1:0] step,
    input  logic              jmp,
    input  logic [WIDTH-1:0]  jmpLoc,
    input  logic              burstStart,
    input  logic [LEN_W-1:0]  burstLen,
    input  logic              clrFlags,
    output logic [WIDTH-1:0]  ctrOut,
    output logic              ovf,
    output logic              unf,
    output logic              busy,
    output logic              atHi,
    output logic              atLo
);

    // state  | meaning
    // IDLE   | single-cycle step/jump under en
    // RUN    | burst: one latched step per enabled cycle until remaining hits 0
    localparam logic [0:0] S_IDLE = IDLE;
    localparam logic [0:0] S_RUN  = RUN;

    logic [0:0]        state_q, state_d;
    logic [WIDTH-1:0]  ctr_q, ctr_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic              bdir_q, bdir_d;
    logic [STEP_W-1:0] bstep_q, bstep_d;

    logic              set_ovf, set_unf;
    logic              a_dir;
    logic [STEP_W-1:0] a_step;
    logic [WIDTH-1:0]  a_nxt;
    logic              a_ovf, a_unf;

    // One arithmetic unit serves both modes; RUN feeds it the latched operands.
    assign a_dir  = (state_q == S_RUN) ? bdir_q  : dir;
    assign a_step = (state_q == S_RUN) ? bstep_q : step;

    stk_ctr_arith #(
        .WIDTH  (WIDTH),
        .STEP_W (STEP_W),
        .LO_LIM (LO_LIM),
        .HI_LIM (HI_LIM),
        .SAT    (SAT)
    ) u_arith (
        .cur  (ctr_q),
        .step (a_step),
        .dir  (a_dir),
        .nxt  (a_nxt),
        .ovf  (a_ovf),
        .unf  (a_unf)
    );

    always_comb begin
        state_d = state_q;
        ctr_d   = ctr_q;
        rem_d   = rem_q;
        bdir_d  = bdir_q;
        bstep_d = bstep_q;
        set_ovf = 1'b0;
        set_unf = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (en) begin
                    if (jmp) begin
                        ctr_d = jmpLoc;
                    end else begin
                        ctr_d   = a_nxt;
                        set_ovf = a_ovf;
                        set_unf = a_unf;
                    end
                end
                if (burstStart && (burstLen != '0)) begin
                    bdir_d  = dir;
                    bstep_d = step;
                    rem_d   = burstLen;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (en) begin
                    if (jmp) begin
                        ctr_d   = jmpLoc;
                        rem_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        ctr_d   = a_nxt;
                        set_ovf = a_ovf;
                        set_unf = a_unf;
                        rem_d   = rem_q - LEN_W'(1);
                        if (rem_q == LEN_W'(1)) begin
                            state_d = S_IDLE;
                        end
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                rem_d   = '0;
            end
        endcase

        // Clearing wins over a set raised by the same update.
        if (clrFlags) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end else begin
            ovf_d = ovf_q | set_ovf;
            unf_d = unf_q | set_unf;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            ctr_q   <= RESET_VAL;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            rem_q   <= '0;
            bdir_q  <= 1'b0;
            bstep_q <= '0;
        end else begin
            state_q <= state_d;
            ctr_q   <= ctr_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            rem_q   <= rem_d;
            bdir_q  <= bdir_d;
            bstep_q <= bstep_d;
        end
    end

    assign ctrOut = ctr_q;
    assign ovf    = ovf_q;
    assign unf    = unf_q;
    assign busy   = (state_q == S_RUN);
    assign atHi   = (ctr_q == HI_LIM);
    assign atLo   = (ctr_q == LO_LIM);

endmodule

// File: tb/tb_stk_ctr.sv
// Scoreboard bench for stk_ctr: a wrap instance and a saturate instance share stimulus.
module tb_stk_ctr;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0, jmp = 1'b0, dir = 1'b0, burst_start = 1'b0, clr_flags = 1'b0;
    logic [2:0] step = '0;
    logic [3:0] jmp_loc = '0, burst_len = '0;

    logic [3:0] ctr_w, ctr_s;
    logic       ovf_w, unf_w, busy_w, hi_w, lo_w;
    logic       ovf_s, unf_s, busy_s, hi_s, lo_s;

    always #5 clk = ~clk;

    stk_ctr #(.WIDTH(4), .STEP_W(3), .LEN_W(4), .RESET_VAL(4'd13),
              .LO_LIM(4'd2), .HI_LIM(4'd13), .SAT(1'b0)) u_wrap (
        .clk(clk), .rst(rst), .en(en), .dir(dir), .step(step), .jmp(jmp),
        .jmpLoc(jmp_loc), .burstStart(burst_start), .burstLen(burst_len),
        .clrFlags(clr_flags), .ctrOut(ctr_w), .ovf(ovf_w), .unf(unf_w),
        .busy(busy_w), .atHi(hi_w), .atLo(lo_w));

    stk_ctr #(.WIDTH(4), .STEP_W(3), .LEN_W(4), .RESET_VAL(4'd13),
              .LO_LIM(4'd2), .HI_LIM(4'd13), .SAT(1'b1)) u_sat (
        .clk(clk), .rst(rst), .en(en), .dir(dir), .step(step), .jmp(jmp),
        .jmpLoc(jmp_loc), .burstStart(burst_start), .burstLen(burst_len),
        .clrFlags(clr_flags), .ctrOut(ctr_s), .ovf(ovf_s), .unf(unf_s),
        .busy(busy_s), .atHi(hi_s), .atLo(lo_s));

    typedef struct {
        int         cyc;
        int         sel;
        string      name;
        logic [8:0] exp;
    } exp_t;

    exp_t sb_q[$];
    exp_t cur_e;
    logic [8:0] act;
    int cyc = 0;
    int checks = 0;
    int failures = 0;

    task automatic drv(input logic r, input logic e, input logic j, input logic d,
                       input logic [2:0] s, input logic [3:0] jl, input logic bs,
                       input logic [3:0] bl, input logic cf);
        @(negedge clk);
        rst = r; en = e; jmp = j; dir = d; step = s; jmp_loc = jl;
        burst_start = bs; burst_len = bl; clr_flags = cf;
    endtask

    // Expected state after the coming rising edge; sel 0 = wrap, 1 = saturate.
    task automatic expect_st(input int sel, input string nm, input logic [3:0] c,
                             input logic o, input logic u, input logic b);
        exp_t x;
        x.cyc  = cyc + 1;
        x.sel  = sel;
        x.name = nm;
        x.exp  = {c, o, u, b, (c == 4'd13), (c == 4'd2)};
        sb_q.push_back(x);
    endtask

    task automatic expect_both(input string nm, input logic [3:0] c,
                               input logic o, input logic u, input logic b);
        expect_st(0, nm, c, o, u, b);
        expect_st(1, nm, c, o, u, b);
    endtask

    initial begin : monitor
        forever begin
            @(posedge clk);
            cyc++;
            #2;
            while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
                cur_e = sb_q.pop_front();
                act = (cur_e.sel == 0) ? {ctr_w, ovf_w, unf_w, busy_w, hi_w, lo_w}
                                       : {ctr_s, ovf_s, unf_s, busy_s, hi_s, lo_s};
                checks++;
                if (cur_e.cyc != cyc || act !== cur_e.exp) begin
                    failures++;
                    $display("FAIL %s (dut %0d): got ctr=%0d ovf=%b unf=%b busy=%b atHi=%b atLo=%b, expected ctr=%0d ovf=%b unf=%b busy=%b atHi=%b atLo=%b",
                             cur_e.name, cur_e.sel, act[8:5], act[4], act[3], act[2], act[1], act[0],
                             cur_e.exp[8:5], cur_e.exp[4], cur_e.exp[3], cur_e.exp[2], cur_e.exp[1], cur_e.exp[0]);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL timeout: bench did not complete, pending=%0d expected=0", sb_q.size());
        $fatal(1, "timeout");
    end

    initial begin : stim
        // reset and jump
        drv(0, 0, 0, 0, 3'd0, 4'd0, 0, 4'd0, 0);  expect_both("reset", 4'd13, 0, 0, 0);
        drv(1, 1, 1, 1, 3'd3, 4'd5, 0, 4'd0, 0);  expect_both("jmp_wins", 4'd5, 0, 0, 0);

        // wrap vs saturate on overflow, underflow and same-cycle clear
        drv(1, 1, 1, 0, 3'd0, 4'd12, 0, 4'd0, 0); expect_both("jmp12", 4'd12, 0, 0, 0);
        drv(1, 1, 0, 1, 3'd3, 4'd0, 0, 4'd0, 0);
        expect_st(0, "wrap_inc", 4'd3, 1, 0, 0);
        expect_st(1, "sat_inc", 4'd13, 1, 0, 0);
        drv(1, 1, 0, 0, 3'd4, 4'd0, 0, 4'd0, 0);
        expect_st(0, "wrap_dec", 4'd11, 1, 1, 0);
        expect_st(1, "sat_dec", 4'd9, 1, 0, 0);
        drv(1, 1, 0, 1, 3'd5, 4'd0, 0, 4'd0, 1);
        expect_st(0, "wrap_clr", 4'd4, 0, 0, 0);
        expect_st(1, "sat_clr", 4'd13, 0, 0, 0);

        // saturate at both bounds
        drv(1, 1, 1, 0, 3'd0, 4'd12, 0, 4'd0, 0); expect_both("jmp12b", 4'd12, 0, 0, 0);
        drv(1, 1, 0, 1, 3'd3, 4'd0, 0, 4'd0, 0);
        expect_st(0, "wrap_inc2", 4'd3, 1, 0, 0);
        expect_st(1, "sat_hi", 4'd13, 1, 0, 0);
        drv(1, 1, 1, 0, 3'd0, 4'd4, 0, 4'd0, 0);  expect_both("jmp_keeps_flags", 4'd4, 1, 0, 0);
        drv(1, 1, 0, 0, 3'd7, 4'd0, 0, 4'd0, 0);
        expect_st(0, "wrap_dec7", 4'd9, 1, 1, 0);
        expect_st(1, "sat_lo", 4'd2, 1, 1, 0);
        drv(1, 0, 0, 0, 3'd0, 4'd0, 0, 4'd0, 1);
        expect_st(0, "wrap_clr_hold", 4'd9, 0, 0, 0);
        expect_st(1, "sat_clr_hold", 4'd2, 0, 0, 0);

        // burst with a two-cycle pause
        drv(1, 1, 1, 0, 3'd0, 4'd4, 0, 4'd0, 0);  expect_both("jmp4", 4'd4, 0, 0, 0);
        drv(1, 0, 0, 1, 3'd2, 4'd0, 1, 4'd3, 0);  expect_both("burst_start", 4'd4, 0, 0, 1);
        drv(1, 1, 0, 0, 3'd5, 4'd0, 1, 4'd7, 0);  expect_both("burst_s1", 4'd6, 0, 0, 1);
        drv(1, 0, 0, 0, 3'd0, 4'd0, 0, 4'd0, 0);  expect_both("burst_pause1", 4'd6, 0, 0, 1);
        drv(1, 0, 0, 0, 3'd0, 4'd0, 0, 4'd0, 0);  expect_both("burst_pause2", 4'd6, 0, 0, 1);
        drv(1, 1, 0, 1, 3'd2, 4'd0, 0, 4'd0, 0);  expect_both("burst_s2", 4'd8, 0, 0, 1);
        drv(1, 1, 0, 1, 3'd2, 4'd0, 0, 4'd0, 0);  expect_both("burst_last", 4'd10, 0, 0, 0);
        drv(1, 0, 0, 1, 3'd2, 4'd0, 0, 4'd0, 0);  expect_both("burst_done", 4'd10, 0, 0, 0);

        // abort, zero-length start, zero step
        drv(1, 0, 0, 1, 3'd1, 4'd0, 1, 4'd5, 0);  expect_both("abort_start", 4'd10, 0, 0, 1);
        drv(1, 1, 0, 1, 3'd1, 4'd0, 0, 4'd0, 0);  expect_both("abort_step", 4'd11, 0, 0, 1);
        drv(1, 1, 1, 1, 3'd1, 4'd7, 0, 4'd0, 0);  expect_both("abort_jmp", 4'd7, 0, 0, 0);
        drv(1, 0, 0, 1, 3'd1, 4'd0, 1, 4'd0, 0);  expect_both("len0_noop", 4'd7, 0, 0, 0);
        drv(1, 1, 0, 1, 3'd0, 4'd0, 0, 4'd0, 0);  expect_both("step0_hold", 4'd7, 0, 0, 0);

        // reset in the middle of a burst, then an exact-boundary wrap
        drv(1, 0, 0, 1, 3'd1, 4'd0, 1, 4'd4, 0);  expect_both("rb_start", 4'd7, 0, 0, 1);
        drv(1, 1, 0, 1, 3'd1, 4'd0, 0, 4'd0, 0);  expect_both("rb_step", 4'd8, 0, 0, 1);
        drv(0, 1, 0, 1, 3'd1, 4'd0, 0, 4'd0, 0);  expect_both("rst_mid_burst", 4'd13, 0, 0, 0);
        drv(1, 0, 0, 1, 3'd1, 4'd0, 0, 4'd0, 0);  expect_both("after_rst_idle", 4'd13, 0, 0, 0);
        drv(1, 1, 0, 1, 3'd1, 4'd0, 0, 4'd0, 0);
        expect_st(0, "wrap_hi_plus1", 4'd2, 1, 0, 0);
        expect_st(1, "sat_hi_plus1", 4'd13, 1, 0, 0);

        drv(1, 0, 0, 0, 3'd0, 4'd0, 0, 4'd0, 0);
        repeat (3) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL drain: pending=%0d expected=0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
